mlp_mac_sched: RTL and testbench

Sequential scheduler that evaluates the 64-8-10 int8 MLP on one shared MAC instead of the fully combinational mlp_top array.
- Accepts an input vector as a sample stream and fetches weights from an external synchronous ROM.
- Runs layer 1, then ReLU/requantize, then layer 2, with a running argmax.
- Returns the class and score over a valid/ready handshake.
- Sits between the sample source and the classification consumer.

---
 rtl/mlp_mac_sched.sv | 215 +++++++++++++++++++++
 tb/tb_mlp_mac_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_mac_sched.sv
// Sequential 64-8-10 int8 MLP on one shared MAC, weights streamed from a synchronous ROM.
// Define MLP_LOGIT_OUT_EN to also expose every layer-2 logit on out_logits.
module mlp_mac_sched #(
  parameter int unsigned IN_DIM  = 64,
  parameter int unsigned H_DIM   = 8,
  parameter int unsigned OUT_DIM = 10,
  parameter int unsigned XW      = 8,
  parameter int unsigned WW      = 8,
  parameter int unsigned ACCW    = 32,
  parameter int unsigned AW      = 10,
  parameter int unsigned SHIFT   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       x_valid,
  output logic                       x_ready,
  input  logic [XW-1:0]              x_data,
  output logic [AW-1:0]              w_addr,
  input  logic [WW-1:0]              w_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(OUT_DIM)-1:0] out_class,
  output logic [ACCW-1:0]            out_score,
`ifdef MLP_LOGIT_OUT_EN
  output logic [OUT_DIM*ACCW-1:0]    out_logits,
`endif
  output logic                       busy
);

  localparam int unsigned CLSW = $clog2(OUT_DIM);
  localparam int unsigned CNTW = $clog2(IN_DIM);
  localparam int unsigned KW   = $clog2(IN_DIM + 1);
  localparam int unsigned NW   = $clog2((H_DIM > OUT_DIM) ? H_DIM : OUT_DIM);
  localparam int unsigned HIDW = $clog2(H_DIM);
  localparam int unsigned PW   = XW + WW;
  localparam int unsigned HMAX = (1 << (XW - 1)) - 1;
  localparam logic signed [ACCW-1:0] HSAT = ACCW'(HMAX);

  typedef enum logic [1:0] {S_LOAD, S_L1, S_L2, S_OUT} state_t;

  state_t                 state_q, state_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [KW-1:0]          k_q, k_d;
  logic [NW-1:0]          n_q, n_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [ACCW-1:0] max_q, max_d;
  logic [CLSW-1:0]        cls_q, cls_d;
  logic [XW-1:0]          xbuf_q [IN_DIM];
  logic [XW-1:0]          xbuf_d [IN_DIM];
  logic [XW-1:0]          hid_q [H_DIM];
  logic [XW-1:0]          hid_d [H_DIM];
  logic [AW-1:0]          w_addr_q, w_addr_d;
  logic                   x_ready_q, x_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic [CLSW-1:0]        out_class_q, out_class_d;
  logic [ACCW-1:0]        out_score_q, out_score_d;
`ifdef MLP_LOGIT_OUT_EN
  logic [OUT_DIM-1:0][ACCW-1:0] logits_q, logits_d;
`endif

  logic [KW-1:0]          n_in;
  logic                   last_k;
  logic                   last_n;
  logic signed [XW-1:0]   opnd;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] mac;
  logic signed [ACCW-1:0] relu;
  logic signed [ACCW-1:0] shifted;
  logic [XW-1:0]          hid_val;

  // Shared MAC: operand k-1 times the weight fetched for address issued last cycle
  always_comb begin
    n_in    = (state_q == S_L1) ? KW'(IN_DIM) : KW'(H_DIM);
    last_k  = (k_q == n_in);
    last_n  = (state_q == S_L1) ? (n_q == NW'(H_DIM - 1)) : (n_q == NW'(OUT_DIM - 1));
    opnd    = (state_q == S_L1) ? $signed(xbuf_q[CNTW'(k_q - KW'(1))])
                                : $signed(hid_q[HIDW'(k_q - KW'(1))]);
    prod    = opnd * $signed(w_rdata);
    mac     = acc_q + ACCW'(prod);
    relu    = mac[ACCW-1] ? '0 : mac;
    shifted = relu >>> SHIFT;
    hid_val = (shifted > HSAT) ? XW'(HMAX) : shifted[XW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    n_d         = n_q;
    acc_d       = acc_q;
    max_d       = max_q;
    cls_d       = cls_q;
    xbuf_d      = xbuf_q;
    hid_d       = hid_q;
    w_addr_d    = w_addr_q;
    out_class_d = out_class_q;
    out_score_d = out_score_q;
`ifdef MLP_LOGIT_OUT_EN
    logits_d    = logits_q;
`endif

    case (state_q)
      S_LOAD: begin
        if (x_valid && x_ready_q) begin
          xbuf_d[cnt_q] = x_data;
          cnt_d         = cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(IN_DIM - 1)) begin
            state_d  = S_L1;
            cnt_d    = '0;
            k_d      = '0;
            n_d      = '0;
            acc_d    = '0;
            w_addr_d = '0;
          end
        end
      end
      S_L1, S_L2: begin
        if (k_q != '0) acc_d = mac;
        // ROM layout is contiguous, so the address only pauses on the last fetch of a neuron
        if (k_q != n_in - KW'(1)) w_addr_d = w_addr_q + AW'(1);
        if (last_k) begin
          k_d   = '0;
          acc_d = '0;
          n_d   = n_q + NW'(1);
          if (state_q == S_L1) begin
            hid_d[HIDW'(n_q)] = hid_val;
          end else begin
            if ((n_q == '0) || (mac > max_q)) begin
              max_d = mac;
              cls_d = CLSW'(n_q);
            end
`ifdef MLP_LOGIT_OUT_EN
            logits_d[n_q] = mac;
`endif
          end
          if (last_n) begin
            n_d     = '0;
            state_d = (state_q == S_L1) ? S_L2 : S_OUT;
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_OUT: begin
        if (!out_valid_q) begin
          out_class_d = cls_q;
          out_score_d = max_q;
        end
        if (out_valid_q && out_ready) state_d = S_LOAD;
      end
      default: ;
    endcase

    out_valid_d = (state_q == S_OUT) && !(out_valid_q && out_ready);
    x_ready_d   = (state_d == S_LOAD);
    busy_d      = (state_d != S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      k_q         <= '0;
      n_q         <= '0;
      acc_q       <= '0;
      max_q       <= '0;
      cls_q       <= '0;
      hid_q       <= '{default: '0};
      w_addr_q    <= '0;
      x_ready_q   <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_class_q <= '0;
      out_score_q <= '0;
`ifdef MLP_LOGIT_OUT_EN
      logits_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      n_q         <= n_d;
      acc_q       <= acc_d;
      max_q       <= max_d;
      cls_q       <= cls_d;
      hid_q       <= hid_d;
      w_addr_q    <= w_addr_d;
      x_ready_q   <= x_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_class_q <= out_class_d;
      out_score_q <= out_score_d;
`ifdef MLP_LOGIT_OUT_EN
      logits_q    <= logits_d;
`endif
    end
  end

  // Input sample buffer needs no reset: every run overwrites all entries before use
  always_ff @(posedge clk) begin
    xbuf_q <= xbuf_d;
  end

  assign x_ready   = x_ready_q;
  assign w_addr    = w_addr_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_score = out_score_q;
  assign busy      = busy_q;
`ifdef MLP_LOGIT_OUT_EN
  assign out_logits = logits_q;
`endif

endmodule

// File: tb/tb_mlp_mac_sched.sv
// Self-checking bench for mlp_mac_sched: directed ROM patterns plus random runs vs. a
// plain-arithmetic MLP model; also covers output back-pressure and mid-run reset.
module tb_mlp_mac_sched;

  localparam int IN_DIM  = 64;
  localparam int H_DIM   = 8;
  localparam int OUT_DIM = 10;
  localparam int ACCW    = 32;
  localparam int SHIFT   = 0;
  localparam int L2_BASE = IN_DIM * H_DIM;
  localparam int ROM_N   = L2_BASE + OUT_DIM * H_DIM;
  localparam int LAT     = H_DIM * (IN_DIM + 1) + OUT_DIM * (H_DIM + 1) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 x_valid;
  logic                 x_ready;
  logic [7:0]           x_data;
  logic [9:0]           w_addr;
  logic [7:0]           w_rdata;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           out_class;
  logic [ACCW-1:0]      out_score;
  logic                 busy;
`ifdef MLP_LOGIT_OUT_EN
  logic [OUT_DIM*ACCW-1:0] out_logits;
`endif

  mlp_mac_sched dut (
    .clk       (clk),
    .rst       (rst),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .x_data    (x_data),
    .w_addr    (w_addr),
    .w_rdata   (w_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score),
`ifdef MLP_LOGIT_OUT_EN
    .out_logits(out_logits),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [0:1023];
  int         xv [IN_DIM];
  int         exp_lg [OUT_DIM];
  int         exp_cls;
  int         exp_score;
  bit         exp_armed = 1'b0;
  bit         mon_en = 1'b0;
  int         n_cmp = 0;
  int         n_fail = 0;

  always @(posedge clk) w_rdata <= rom[w_addr];

  task automatic check(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic int wgt(input int a);
    int w;
    w = $signed(rom[a]);
    return w;
  endfunction

  // Reference network evaluated directly from the mathematical definition
  function automatic void model();
    int hid [H_DIM];
    int acc;
    for (int h = 0; h < H_DIM; h++) begin
      acc = 0;
      for (int i = 0; i < IN_DIM; i++) acc += xv[i] * wgt(h * IN_DIM + i);
      if (acc < 0) acc = 0;
      acc = acc >>> SHIFT;
      if (acc > 127) acc = 127;
      hid[h] = acc;
    end
    for (int o = 0; o < OUT_DIM; o++) begin
      acc = 0;
      for (int h = 0; h < H_DIM; h++) acc += hid[h] * wgt(L2_BASE + o * H_DIM + h);
      exp_lg[o] = acc;
    end
    exp_cls   = 0;
    exp_score = exp_lg[0];
    for (int o = 1; o < OUT_DIM; o++)
      if (exp_lg[o] > exp_score) begin
        exp_cls   = o;
        exp_score = exp_lg[o];
      end
  endfunction

  // Per-cycle output checker
  always @(negedge clk) begin
    if (mon_en) begin
      check("ready_vs_busy", longint'(x_ready), longint'(!busy));
      if (out_valid) begin
        if (!exp_armed) check("spurious_valid", 1, 0);
        else begin
          check("out_class", longint'(out_class), exp_cls);
          check("out_score", longint'($signed(out_score)), exp_score);
`ifdef MLP_LOGIT_OUT_EN
          for (int k = 0; k < OUT_DIM; k++)
            check("out_logit", longint'($signed(out_logits[k*ACCW +: ACCW])), exp_lg[k]);
`endif
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_x_ready", longint'(x_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_class", longint'(out_class), 0);
    check("rst_out_score", longint'(out_score), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_w_addr", longint'(w_addr), 0);
  endtask

  task automatic send_vec();
    for (int i = 0; i < IN_DIM; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        x_valid = 1'b0;
        x_data  = 8'($urandom);
        @(posedge clk); #1;
      end
      x_valid = 1'b1;
      x_data  = 8'(xv[i]);
      check("x_ready_load", longint'(x_ready), 1);
      @(posedge clk); #1;
    end
    x_valid = 1'b0;
  endtask

  task automatic run(input int hold, input bit pulses);
    int n;
    model();
    exp_armed = 1'b1;
    send_vec();
    check("busy_after_load", longint'(busy), 1);
    n = 0;
    while (!out_valid && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, LAT);
    if (out_valid) begin
      for (int j = 0; j < hold; j++) begin
        if (pulses) begin
          x_valid = 1'($urandom_range(0, 1));
          x_data  = 8'($urandom);
        end
        check("x_ready_out", longint'(x_ready), 0);
        @(posedge clk); #1;
      end
      x_valid   = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("hs_out_valid", longint'(out_valid), 0);
      check("hs_x_ready", longint'(x_ready), 1);
      check("hs_busy", longint'(busy), 0);
    end
    exp_armed = 1'b0;
  endtask

  task automatic rand_x(input int mag);
    for (int i = 0; i < IN_DIM; i++)
      xv[i] = (mag == 0) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 2 * mag)) - mag;
  endtask

  task automatic rand_rom(input int mag);
    for (int a = 0; a < ROM_N; a++)
      rom[a] = (mag == 0) ? 8'($urandom) : 8'(int'($urandom_range(0, 2 * mag)) - mag);
  endtask

  task automatic fill_rom(input int l1, input int row_a, input int row_b, input bit row_idx);
    for (int a = 0; a < L2_BASE; a++) rom[a] = 8'(l1);
    for (int o = 0; o < OUT_DIM; o++)
      for (int h = 0; h < H_DIM; h++)
        rom[L2_BASE + o * H_DIM + h] = row_idx ? 8'(o) : ((o == row_a || o == row_b) ? 8'd1 : 8'd0);
  endtask

  task automatic const_x(input int v);
    for (int i = 0; i < IN_DIM; i++) xv[i] = v;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    x_valid   = 1'b0;
    x_data    = '0;
    out_ready = 1'b0;
    for (int a = 0; a < 1024; a++) rom[a] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    do_reset();
    mon_en = 1'b1;

    // All-zero ROM
    rand_x(0);
    model();
    check("pin_zero_cls", exp_cls, 0);
    check("pin_zero_score", exp_score, 0);
    run(0, 1'b0);

    // Unit layer 1, row o weighted o
    const_x(1);
    fill_rom(1, -1, -1, 1'b1);
    model();
    check("pin_ramp_cls", exp_cls, 9);
    check("pin_ramp_score", exp_score, 4608);
    run(2, 1'b0);

    // Hidden saturation to 127
    const_x(127);
    fill_rom(127, 3, 3, 1'b0);
    model();
    check("pin_sat_cls", exp_cls, 3);
    check("pin_sat_score", exp_score, 1016);
    run(1, 1'b0);

    // ReLU clamps negatives: all logits zero
    const_x(1);
    fill_rom(-1, 2, 5, 1'b0);
    model();
    check("pin_relu_cls", exp_cls, 0);
    check("pin_relu_score", exp_score, 0);
    run(0, 1'b0);

    // Tie between rows 2 and 5 resolves to the lower index
    fill_rom(1, 2, 5, 1'b0);
    model();
    check("pin_tie_cls", exp_cls, 2);
    check("pin_tie_score", exp_score, 512);
    run(0, 1'b0);

    // Back-pressure with ignored input pulses
    rand_x(0);
    rand_rom(3);
    run(20, 1'b1);

    // Abort mid layer 1, then a fresh vector
    rand_x(0);
    send_vec();
    repeat (100) begin
      @(posedge clk); #1;
    end
    do_reset();
    rand_x(5);
    rand_rom(0);
    run(1, 1'b0);

    // Random runs
    for (int r = 0; r < 4; r++) begin
      rand_x((r % 2 == 0) ? 0 : 4);
      rand_rom((r % 2 == 0) ? 2 : 0);
      run(int'($urandom_range(0, 3)), 1'b1);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
